// File: rtl/spi_reg_pkg.sv
// Shared state encoding, frame geometry and command-byte helper for spi_reg_master.
package spi_reg_pkg;

  localparam int unsigned ADDR_W        = 2;
  localparam int unsigned CMD_RD_BIT    = 7;
  localparam int unsigned WR_CYCLES     = 16;
  localparam int unsigned RD_CYCLES     = 24;
  localparam int unsigned RD_DATA_START = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GUARD = 3'd5
  } spi_state_e;

  function automatic logic [7:0] build_cmd(input logic write, input logic [ADDR_W-1:0] addr);
    logic [7:0] cmd;
    cmd             = '0;
    cmd[CMD_RD_BIT] = ~write;
    cmd[ADDR_W-1:0] = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// Request/response handshake between a register client and spi_reg_master.
interface spi_reg_master_if;
  import spi_reg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: one-clk tick every HALF_DIV clk while not held clear.
module spi_clk_tick #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);

  logic [7:0] div_cnt;

  assign tick = !clear && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 8'd1;
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI register master (CPOL=0, mosi launched on rising sclk, sampled on falling).
// Define SPIM_CS_GUARD_EN to add a GUARD state keeping cs high 2*HALF_DIV clk before DONE.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_reg_master_if.slave         reg_if,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic                    cs
);

  spi_state_e  state;
  logic        tick;
  logic        tick_clr;
  logic        accept;
  logic        wr_q;
  logic [15:0] tx_sr;
  logic [7:0]  rx_sr;
  logic [4:0]  cyc_cnt;
  logic [4:0]  cyc_nxt;
  logic        last_cycle;
  logic [7:0]  cmd_byte;
`ifdef SPIM_CS_GUARD_EN
  logic        guard_half;
`endif

  assign reg_if.req_ready = (state == ST_IDLE);
  assign accept           = reg_if.req_valid && reg_if.req_ready;
  assign tick_clr         = (state == ST_IDLE) || (state == ST_DONE);
  assign cyc_nxt          = cyc_cnt + 5'd1;
  assign last_cycle       = (cyc_nxt == (wr_q ? 5'(WR_CYCLES) : 5'(RD_CYCLES)));
  assign cmd_byte         = build_cmd(reg_if.req_write, reg_if.req_addr);

  spi_clk_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      sclk             <= 1'b0;
      mosi             <= 1'b0;
      cs               <= 1'b1;
      wr_q             <= 1'b0;
      tx_sr            <= '0;
      rx_sr            <= '0;
      cyc_cnt          <= '0;
      reg_if.rsp_valid <= 1'b0;
      reg_if.rsp_rdata <= '0;
`ifdef SPIM_CS_GUARD_EN
      guard_half       <= 1'b0;
`endif
    end else begin
      reg_if.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // Command bit 7 goes out in SETUP; the rest queue behind it, zero-padded for reads.
            wr_q    <= reg_if.req_write;
            cs      <= 1'b0;
            mosi    <= cmd_byte[7];
            tx_sr   <= {cmd_byte[6:0], (reg_if.req_write ? reg_if.req_wdata : 8'h00), 1'b0};
            rx_sr   <= '0;
            cyc_cnt <= '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
              if (cyc_cnt != 5'd0) begin
                mosi  <= tx_sr[15];
                tx_sr <= {tx_sr[14:0], 1'b0};
              end
            end else begin
              sclk    <= 1'b0;
              cyc_cnt <= cyc_nxt;
              if (!wr_q && (cyc_nxt >= 5'(RD_DATA_START))) rx_sr <= {rx_sr[6:0], miso};
              if (last_cycle) state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs   <= 1'b1;
            mosi <= 1'b0;
`ifdef SPIM_CS_GUARD_EN
            guard_half <= 1'b0;
            state      <= ST_GUARD;
`else
            reg_if.rsp_valid <= 1'b1;
            reg_if.rsp_rdata <= rx_sr;
            state            <= ST_DONE;
`endif
          end
        end
`ifdef SPIM_CS_GUARD_EN
        ST_GUARD: begin
          if (tick) begin
            if (guard_half) begin
              reg_if.rsp_valid <= 1'b1;
              reg_if.rsp_rdata <= rx_sr;
              state            <= ST_DONE;
            end else begin
              guard_half <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: HALF_DIV=2 and HALF_DIV=1 instances with a shared peripheral model.
module tb_spi_reg_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic       req_valid;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] pdata;
  logic       tie1;
  logic       miso = 1'b0;

  logic sclk0, mosi0, cs0, sclk1, mosi1, cs1;

  spi_reg_master_if bus0 ();
  spi_reg_master_if bus1 ();

  assign bus0.req_valid = req_valid && !sel;
  assign bus1.req_valid = req_valid && sel;
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;

  spi_reg_master #(.HALF_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .reg_if(bus0.slave),
    .sclk(sclk0), .mosi(mosi0), .miso(miso), .cs(cs0)
  );

  spi_reg_master #(.HALF_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .reg_if(bus1.slave),
    .sclk(sclk1), .mosi(mosi1), .miso(miso), .cs(cs1)
  );

  logic       sclk_m, mosi_m, cs_m, rdy_m, rspv_m;
  logic [7:0] rdata_m;
  assign sclk_m  = sel ? sclk1 : sclk0;
  assign mosi_m  = sel ? mosi1 : mosi0;
  assign cs_m    = sel ? cs1 : cs0;
  assign rdy_m   = sel ? bus1.req_ready : bus0.req_ready;
  assign rspv_m  = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign rdata_m = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

`ifdef SPIM_CS_GUARD_EN
  localparam int unsigned GAP_EXP = 2 * 2 + 2;
`else
  localparam int unsigned GAP_EXP = 2;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Free-running monitor and peripheral; the sequence snapshots its counters.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sclk_prev = 1'b0;
  logic        cs_prev   = 1'b1;
  logic [31:0] mosi_sr   = '0;
  int unsigned rise_cnt = 0, frame_rise = 0, rise_cyc = 0, rise_period = 0;
  int unsigned cs_hi_run = 0, cs_lo_run = 0, last_gap = 0, last_low = 0;
  int unsigned rsp_cnt = 0, acc_cnt = 0, acc_cyc = 0;

  always @(negedge clk) begin
    if (!sclk_prev && sclk_m) begin
      rise_cnt    <= rise_cnt + 1;
      frame_rise  <= frame_rise + 1;
      rise_period <= cyc - rise_cyc;
      rise_cyc    <= cyc;
      if (frame_rise >= 16 && frame_rise <= 23)
        miso <= tie1 ? 1'b1 : pdata[3'(23 - frame_rise)];
    end
    if (sclk_prev && !sclk_m) mosi_sr <= {mosi_sr[30:0], mosi_m};
    if (cs_m) begin
      if (!cs_prev) last_low <= cs_lo_run;
      cs_hi_run  <= cs_hi_run + 1;
      cs_lo_run  <= 0;
      frame_rise <= 0;
      miso       <= tie1;
    end else begin
      if (cs_prev) last_gap <= cs_hi_run;
      cs_lo_run <= cs_lo_run + 1;
      cs_hi_run <= 0;
    end
    if (rspv_m) rsp_cnt <= rsp_cnt + 1;
    if (req_valid && rdy_m) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    sclk_prev <= sclk_m;
    cs_prev   <= cs_m;
  end

  task automatic wait_ready();
    int unsigned n = 0;
    while (!rdy_m && n < 200) begin @(negedge clk); n++; end
    check("ready_wait", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_rsp(output logic [7:0] rd);
    int unsigned n = 0;
    while (!rspv_m && n < 1000) begin @(negedge clk); n++; end
    check("rsp_wait", 32'(n < 1000), 32'd1);
    rd = rdata_m;
  endtask

  task automatic do_txn(input logic w, input logic [1:0] a, input logic [7:0] d, output logic [7:0] rd);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(rd);
  endtask

  initial begin
    logic [7:0]  rd;
    int unsigned r0, v0, done1, a0, n;

    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; pdata = '0; tie1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs",    32'(cs0), 32'd1);
    check("rst_sclk",  32'(sclk0), 32'd0);
    check("rst_mosi",  32'(mosi0), 32'd0);
    check("rst_ready", 32'(bus0.req_ready), 32'd1);
    check("rst_rspv",  32'(bus0.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus0.rsp_rdata), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write addr=2 data=0xA5
    r0 = rise_cnt; v0 = rsp_cnt;
    do_txn(1'b1, 2'd2, 8'hA5, rd);
    repeat (4) @(negedge clk);
    check("wr_mosi",   32'(mosi_sr[15:0]), 32'h02A5);
    check("wr_rises",  rise_cnt - r0, 32'd16);
    check("wr_cs_low", last_low, 32'd68);
    check("wr_rsp1",   rsp_cnt - v0, 32'd1);
    check("wr_rdata",  32'(rd), 32'd0);
    check("idle_cs",   32'(cs_m), 32'd1);
    check("idle_sclk", 32'(sclk_m), 32'd0);
    check("idle_mosi", 32'(mosi_m), 32'd0);

    // Read addr=1, peripheral returns 0x3C
    pdata = 8'h3C;
    r0 = rise_cnt;
    do_txn(1'b0, 2'd1, 8'hFF, rd);
    repeat (4) @(negedge clk);
    check("rd_rdata",  32'(rd), 32'h3C);
    check("rd_mosi",   32'(mosi_sr[23:0]), 32'h810000);
    check("rd_rises",  rise_cnt - r0, 32'd24);
    check("rd_cs_low", last_low, 32'd100);
    check("rd_hold",   32'(bus0.rsp_rdata), 32'h3C);

    // Back-to-back: write 0x96 to addr 3, then read addr 3 with req_valid held high
    pdata = 8'hC3;
    @(negedge clk);
    req_write = 1'b1; req_addr = 2'd3; req_wdata = 8'h96; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = 8'h00;
    wait_rsp(rd);
    done1 = cyc;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 200) begin @(negedge clk); n++; end
    check("b2b_acc_wait", 32'(n < 200), 32'd1);
    check("b2b_acc_after_done", 32'(acc_cyc >= done1 + 1), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(rd);
    repeat (4) @(negedge clk);
    check("b2b_rdata", 32'(rd), 32'hC3);
    check("b2b_mosi",  mosi_sr, 32'h96830000);
    check("b2b_gap",   last_gap, GAP_EXP);

    // Reset in SCLK cycle 10 of a read
    @(negedge clk);
    req_write = 1'b0; req_addr = 2'd1; req_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    v0 = rsp_cnt;
    n = 0;
    while (frame_rise != 10 && n < 500) begin @(negedge clk); n++; end
    check("rst10_wait", 32'(n < 500), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst10_cs",    32'(cs_m), 32'd1);
    check("rst10_sclk",  32'(sclk_m), 32'd0);
    check("rst10_ready", 32'(rdy_m), 32'd1);
    check("rst10_rspv",  32'(rspv_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("rst10_norsp", rsp_cnt - v0, 32'd0);
    check("rst10_rdata", 32'(rdata_m), 32'd0);

    // HALF_DIV=1 instance, miso tied high
    sel = 1'b1; tie1 = 1'b1;
    repeat (3) @(negedge clk);
    r0 = rise_cnt;
    do_txn(1'b0, 2'd2, 8'h00, rd);
    repeat (4) @(negedge clk);
    check("hd1_rdata",  32'(rd), 32'hFF);
    check("hd1_period", rise_period, 32'd2);
    check("hd1_rises",  rise_cnt - r0, 32'd24);
    check("hd1_cs_low", last_low, 32'd50);
    check("hd1_mosi",   32'(mosi_sr[23:0]), 32'h820000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
